// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-side transmitter.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StWaitDev,
        StData,
        StWaitIdle,
        StError
    } ps2_tx_state_t;

    localparam logic [7:0] Ps2CmdSetLeds = 8'hED;
    localparam logic [7:0] Ps2CmdReset   = 8'hFF;
    localparam logic [7:0] Ps2CmdEnable  = 8'hF4;
    localparam logic [7:0] Ps2Ack        = 8'hFA;

    // Integer cycle count for a duration in microseconds; 64-bit to survive long timeouts.
    function automatic int unsigned us_to_cycles(input int unsigned freq_hz, input int unsigned us);
        return 32'((64'(freq_hz) * 64'(us)) / 64'd1_000_000);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stability filter for one PS/2 line, with a falling-edge strobe
// on the filtered level.
module ps2_line_filter
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned FilterLen = 8
) (
    input  logic clk,
    input  logic nreset,
    input  logic line,
    output logic filtered,
    output logic fall
);

    localparam int unsigned CntW = (FilterLen > 1) ? $clog2(FilterLen) : 1;

    logic [1:0]      sync_q;
    logic            filt_q, filt_d;
    logic            fall_q, fall_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Idle bus is pulled high, so the filter comes out of reset reading 1.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], line};
            filt_q <= filt_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        filt_d = filt_q;
        fall_d = 1'b0;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CntW'(FilterLen - 1)) begin
                filt_d = sync_q[1];
                fall_d = filt_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    assign filtered = filt_q;
    assign fall     = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send, shifts one
// byte out on device-generated clocks and checks the device ACK.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned ClkFreqHz       = 7_000_000,
    parameter int unsigned InhibitUs       = 120,
    parameter int unsigned StartTimeoutUs  = 15000,
    parameter int unsigned PacketTimeoutUs = 2000,
    parameter int unsigned FilterLen       = 8
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned NInh   = us_to_cycles(ClkFreqHz, InhibitUs);
    localparam int unsigned NSt    = us_to_cycles(ClkFreqHz, StartTimeoutUs);
    localparam int unsigned NPk    = us_to_cycles(ClkFreqHz, PacketTimeoutUs);
    localparam int unsigned NMax   = (NSt > NPk) ? ((NSt > NInh) ? NSt : NInh)
                                                 : ((NPk > NInh) ? NPk : NInh);
    localparam int unsigned TimerW = $clog2(NMax + 1);

    logic clk_filt, clk_fall, dat_filt, dat_fall_unused;

    ps2_line_filter #(.FilterLen(FilterLen)) u_clk_filter (
        .clk      (clk),
        .nreset   (nreset),
        .line     (ps2_clk_i),
        .filtered (clk_filt),
        .fall     (clk_fall)
    );

    ps2_line_filter #(.FilterLen(FilterLen)) u_dat_filter (
        .clk      (clk),
        .nreset   (nreset),
        .line     (ps2_dat_i),
        .filtered (dat_filt),
        .fall     (dat_fall_unused)
    );

    ps2_tx_state_t     state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [9:0]        shift_q, shift_d;
    logic [3:0]        bit_q, bit_d;
    logic              dat_oe_q, dat_oe_d;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            shift_q  <= '0;
            bit_q    <= '0;
            dat_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + TimerW'(1);
        shift_d    = shift_q;
        bit_d      = bit_q;
        dat_oe_d   = dat_oe_q;
        tx_done    = 1'b0;
        tx_error   = 1'b0;
        tx_ready   = (state_q == StIdle);
        tx_busy    = (state_q != StIdle);
        ps2_clk_oe = (state_q == StInhibit);
        ps2_dat_oe = dat_oe_q;

        unique case (state_q)
            StIdle: begin
                timer_d  = '0;
                bit_d    = '0;
                dat_oe_d = 1'b0;
                if (tx_valid) begin
                    state_d = StInhibit;
                    shift_d = {1'b1, ~^tx_data, tx_data};
                end
            end
            StInhibit: begin
                // Start bit goes low one cycle before CLK is released.
                if (timer_q == TimerW'(NInh - 1)) begin
                    dat_oe_d = 1'b1;
                end else if (timer_q == TimerW'(NInh)) begin
                    state_d = StWaitDev;
                    timer_d = '0;
                end
            end
            StWaitDev: begin
                if (clk_fall) begin
                    state_d  = StData;
                    timer_d  = '0;
                    dat_oe_d = ~shift_q[0];
                    shift_d  = shift_q >> 1;
                    bit_d    = 4'd1;
                end else if (timer_q == TimerW'(NSt - 1)) begin
                    state_d  = StError;
                    dat_oe_d = 1'b0;
                end
            end
            StData: begin
                if (clk_fall && bit_q == 4'd10) begin
                    state_d  = dat_filt ? StError : StWaitIdle;
                    dat_oe_d = 1'b0;
                end else if (timer_q == TimerW'(NPk - 1)) begin
                    state_d  = StError;
                    dat_oe_d = 1'b0;
                end else if (clk_fall) begin
                    dat_oe_d = ~shift_q[0];
                    shift_d  = shift_q >> 1;
                    bit_d    = bit_q + 4'd1;
                end
            end
            StWaitIdle: begin
                if (clk_filt && dat_filt) begin
                    tx_done = 1'b1;
                    state_d = StIdle;
                end else if (timer_q == TimerW'(NPk - 1)) begin
                    state_d = StError;
                end
            end
            StError: begin
                tx_error = 1'b1;
                dat_oe_d = 1'b0;
                state_d  = StIdle;
            end
            default: begin
                state_d  = StIdle;
                dat_oe_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and every
// frame is compared against a reference built from the byte value.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int ClkHz = 1_000_000;
    localparam int NInh  = int'(64'(ClkHz) * 120 / 1_000_000);
    localparam int NSt   = int'(64'(ClkHz) * 15000 / 1_000_000);
    localparam int NPk   = int'(64'(ClkHz) * 2000 / 1_000_000);
    localparam int Half  = 20;  // device half period in clk cycles (40 us period at 1 MHz)

    localparam int ModeAck    = 0;
    localparam int ModeNoAck  = 1;
    localparam int ModeSilent = 2;
    localparam int ModeReset  = 3;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       bfm_clk_low = 1'b0;
    logic       bfm_dat_low = 1'b0;
    logic       glitch = 1'b0;
    logic       clk_line, dat_line;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int acc_cnt = 0;

    assign clk_line = ~(ps2_clk_oe | bfm_clk_low | glitch);
    assign dat_line = ~(ps2_dat_oe | bfm_dat_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .ClkFreqHz       (ClkHz),
        .InhibitUs       (120),
        .StartTimeoutUs  (15000),
        .PacketTimeoutUs (2000),
        .FilterLen       (8)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_i  (clk_line),
        .ps2_dat_i  (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always @(negedge clk) begin
        if (nreset) begin
            if (tx_done) done_cnt <= done_cnt + 1;
            if (tx_error) err_cnt <= err_cnt + 1;
            if (tx_done && tx_error) both_cnt <= both_cnt + 1;
            if (tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame as the device sees it: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i + 1] = d[i];
        f[9]  = ($countones(d) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] d, input int mode, input bit hold, input bit glitchy);
        int          n;
        int          acc0, done0, err0;
        logic [10:0] frame;
        frame = '0;
        @(negedge clk);
        check("ready_before", tx_ready, 1);
        acc0  = acc_cnt;
        done0 = done_cnt;
        err0  = err_cnt;
        @(posedge clk);
        #1;
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("clk_low_latency", ps2_clk_oe, 1);
        if (hold) tx_data = ~d;
        else tx_valid = 1'b0;
        n = 1;
        while (!ps2_dat_oe && n < NInh + 50) begin
            @(negedge clk);
            if (ps2_clk_oe && !ps2_dat_oe) n++;
        end
        check("inhibit_cycles", n, NInh);
        check("clk_held_at_start", ps2_clk_oe, 1);
        n = 0;
        while (ps2_clk_oe && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("clk_release_after_start", n, 1);
        frame[0] = dat_line;

        if (mode == ModeSilent) begin
            n = 0;
            while (!tx_error && n < NSt + 100) begin
                @(negedge clk);
                n++;
            end
            check("start_timeout", (n >= NSt - 1 && n <= NSt + 2), 1);
            check("err_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
            check("err_no_done", tx_done, 0);
        end else begin
            repeat (30) @(negedge clk);
            for (int k = 1; k <= 11; k++) begin
                if (k == 11) begin
                    repeat (Half - 5) @(negedge clk);
                    if (mode == ModeAck) bfm_dat_low = 1'b1;
                    repeat (5) @(negedge clk);
                end else if (k > 1) begin
                    if (glitchy) begin
                        repeat (8) @(negedge clk);
                        #4 glitch = 1'b1;
                        #2 glitch = 1'b0;
                        @(negedge clk);
                        repeat (2) @(negedge clk);
                        glitch = 1'b1;
                        repeat (3) @(negedge clk);
                        glitch = 1'b0;
                        repeat (Half - 14) @(negedge clk);
                    end else begin
                        repeat (Half) @(negedge clk);
                    end
                end
                bfm_clk_low = 1'b1;
                if (mode == ModeReset && k == 5) begin
                    repeat (15) @(negedge clk);
                    #2 nreset = 1'b0;
                    #1;
                    check("rst_oe_release", {ps2_clk_oe, ps2_dat_oe}, 0);
                    check("rst_busy", tx_busy, 0);
                    check("rst_no_pulse", {tx_done, tx_error}, 0);
                    bfm_clk_low = 1'b0;
                    tx_valid = 1'b0;
                    repeat (3) @(negedge clk);
                    nreset = 1'b1;
                    repeat (20) @(negedge clk);
                    check("rst_idle_ready", {tx_ready, tx_busy}, 2'b10);
                    check("rst_no_done_err", (done_cnt - done0) + (err_cnt - err0), 0);
                    return;
                end
                repeat (Half) @(negedge clk);
                bfm_clk_low = 1'b0;
                if (k <= 10) frame[k] = dat_line;
            end
            bfm_dat_low = 1'b0;
            n = 0;
            while (!(tx_done || tx_error) && done_cnt == done0 && err_cnt == err0 && n < NPk) begin
                @(negedge clk);
                n++;
            end
            if (hold) tx_valid = 1'b0;
            check("frame", frame, model_frame(d));
        end

        repeat (4) @(negedge clk);
        check("done_count", done_cnt - done0, (mode == ModeAck) ? 1 : 0);
        check("err_count", err_cnt - err0, (mode == ModeAck) ? 0 : 1);
        check("accepts", acc_cnt - acc0, 1);
        check("idle_ready", {tx_ready, tx_busy}, 2'b10);
        check("idle_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        repeat (3) @(negedge clk);
        check("reset_ready_busy", {tx_ready, tx_busy}, 2'b10);
        check("reset_pulses", {tx_done, tx_error}, 0);
        check("reset_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        nreset = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_ready", tx_ready, 1);

        send(Ps2CmdSetLeds, ModeAck, 1'b0, 1'b0);
        send(8'h00, ModeAck, 1'b0, 1'b0);
        send(8'h01, ModeAck, 1'b0, 1'b0);
        send(8'h3C, ModeSilent, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        send(Ps2CmdEnable, ModeNoAck, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        send(Ps2CmdReset, ModeAck, 1'b0, 1'b0);
        send(8'h5A, ModeReset, 1'b0, 1'b0);
        send(Ps2CmdSetLeds, ModeAck, 1'b1, 1'b1);
        for (int r = 0; r < 6; r++) begin
            d = 8'($urandom_range(0, 255));
            send(d, ModeAck, (r % 2) == 1, (r % 3) == 0);
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end

        check("done_err_exclusive", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
